// File: rtl/disp_pkg.sv
// disp_pkg: shared helpers for the round-robin stream dispatcher.
package disp_pkg;
    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] PTR_RST = MAX_W'(1);

    function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++)
            if (i < w) r[(i + 1) % w] = v[i];
        return r;
    endfunction

    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction
endpackage

// File: rtl/arb_fp.sv
// arb_fp: grants the first requester at or above the one-hot priority position, wrapping around.
module arb_fp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] v_vld,
    input  logic [WIDTH-1:0] v_priority,
    output logic [WIDTH-1:0] v_gnt
);
    logic [2*WIDTH-1:0] w_dbl;
    logic [2*WIDTH-1:0] w_gnt;

    // Doubling the request vector lets the borrow chain wrap past the top lane.
    assign w_dbl = {v_vld, v_vld};
    assign w_gnt = w_dbl & ~(w_dbl - {{WIDTH{1'b0}}, v_priority});
    assign v_gnt = w_gnt[WIDTH-1:0] | w_gnt[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/disp_rr.sv
// disp_rr: 1-to-WIDTH valid/ready dispatcher with round-robin lane choice and per-lane holding registers.
module disp_rr
    import disp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [WIDTH-1:0]        in_dest_mask,
    output logic [WIDTH-1:0]        v_out_vld,
    input  logic [WIDTH-1:0]        v_out_rdy,
    output logic [WIDTH*DATA_W-1:0] out_data,
    output logic [WIDTH-1:0]        v_sel,
    output logic [CNT_W-1:0]        drop_cnt
);
    logic [WIDTH-1:0] r_ptr;
    logic [WIDTH-1:0] w_free;
    logic [WIDTH-1:0] w_elig;
    logic [WIDTH-1:0] w_gnt;
    logic [WIDTH-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] r_drop;
    logic             w_drop;

    // A lane draining this cycle is free, so each lane sustains one beat per cycle.
    assign w_free    = ~v_out_vld | v_out_rdy;
    assign w_elig    = in_dest_mask & w_free;
    assign in_rdy    = (|w_elig) | ~(|in_dest_mask);
    assign v_sel     = (in_vld & (|w_elig)) ? w_gnt : '0;
    assign w_drop    = in_vld & ~(|in_dest_mask);
    assign w_ptr_nxt = WIDTH'(rotl1(MAX_W'(v_sel), WIDTH));
    assign drop_cnt  = r_drop;

    arb_fp #(.WIDTH(WIDTH)) u_arb (
        .v_vld      (w_elig),
        .v_priority (r_ptr),
        .v_gnt      (w_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ptr <= WIDTH'(PTR_RST);
        else if (|v_sel) r_ptr <= w_ptr_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_drop <= '0;
        else if (w_drop && !(&r_drop)) r_drop <= r_drop + 1'b1;
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        logic              r_v;
        logic [DATA_W-1:0] r_d;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_d <= '0;
            end else if (v_sel[g]) begin
                r_v <= 1'b1;
                r_d <= in_data;
            end else if (v_out_rdy[g]) begin
                r_v <= 1'b0;
            end
        end
        assign v_out_vld[g] = r_v;
        assign out_data[lane_lsb(g, DATA_W) +: DATA_W] = r_d;
    end
endmodule
